// File: rtl/dir_lut_pkg.sv
// dir_lut_pkg: shared widths, controller FSM encoding and round-robin pick for shared-ROM controllers
package dir_lut_pkg;
    localparam int DIR_ADDR_W = 8;
    localparam int DIR_DATA_W = 5;
    localparam int MAX_REQ = 8;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } arb_state_t;
    // One-hot grant of the first valid requester after ptr, wrapping modulo n (n <= MAX_REQ)
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
        logic [MAX_REQ-1:0] g;
        logic [2:0] idx;
        g = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k <= n && g == '0 && valid[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction
endpackage

// File: rtl/dir_lut_arbiter_rr.sv
// rr_arbiter: combinational one-hot round-robin pick with the last-granted pointer register
module rr_arbiter
    import dir_lut_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr;
    assign gnt = en ? N'(rr_pick(MAX_REQ'(req), 3'(ptr), N)) : '0;
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) idx = gnt[i] ? PW'(i) : idx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= PW'(N - 1);
        else if (|gnt) ptr <= idx;
    end
endmodule

// File: rtl/dir_lut_arbiter.sv
// dir_lut_arbiter: round-robin sharing of one orientation-bin ROM through a 2-stage pipeline with hold/drain.
// Optional per-requester grant counters when DIR_LUT_ARB_STATS_EN is defined.
module dir_lut_arbiter
    import dir_lut_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DIR_ADDR_W,
    parameter int DATA_W  = DIR_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_a,
    input  logic [DATA_W-1:0]         rom_spo,
    input  logic                      hold,
    output logic                      idle
`ifdef DIR_LUT_ARB_STATS_EN
    ,
    input  logic                      cnt_clr,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_t state, nxt;
    logic [IW-1:0] gidx, s1_id;
    logic s1_vld, acc, empty;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (state == RUN && !hold),
        .gnt (req_ready),
        .idx (gidx)
    );
    assign acc = |(req_valid & req_ready);
    assign empty = !s1_vld && rsp_valid == '0;
    assign idle = state == PAUSED || empty;
    // Dropping hold while still draining resumes granting without waiting for the pipeline
    always_comb begin
        nxt = state;
        case (state)
            RUN:     nxt = hold ? DRAIN : RUN;
            DRAIN:   nxt = !hold ? RUN : empty ? PAUSED : DRAIN;
            PAUSED:  nxt = hold ? PAUSED : RUN;
            default: nxt = RUN;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_id  <= '0;
            rom_a  <= '0;
        end else begin
            s1_vld <= acc;
            if (acc) begin
                rom_a <= req_addr[gidx*ADDR_W +: ADDR_W];
                s1_id <= gidx;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_vld ? NUM_REQ'(1) << s1_id : '0;
            if (s1_vld) rsp_data <= rom_spo;
        end
    end
`ifdef DIR_LUT_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) grant_cnt[g*16 +: 16] <= '0;
            else if (cnt_clr) grant_cnt[g*16 +: 16] <= '0;
            else if (req_valid[g] && req_ready[g] && grant_cnt[g*16 +: 16] != 16'hFFFF)
                grant_cnt[g*16 +: 16] <= grant_cnt[g*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dir_lut_arbiter.sv
// tb_dir_lut_arbiter: directed vector table, queue-based reference model under random stimulus, reset and stats corners
module tb_dir_lut_arbiter;
    localparam int N = 4;
    localparam logic [31:0] A = 32'hFFF07F10;
    logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic [N*8-1:0] req_addr = '0;
    logic [4:0] rsp_data, rom_spo;
    logic [7:0] rom_a;
    logic idle;
`ifdef DIR_LUT_ARB_STATS_EN
    logic cnt_clr = 1'b0;
    logic [N*16-1:0] grant_cnt;
`endif
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    // Orientation-bin table: upper half of the angle range maps to bins 0..7, lower half to 24..31
    function automatic logic [4:0] rom_f(input logic [7:0] a);
        return (a[7] ? 5'd0 : 5'd24) + {2'b00, a[6:4]};
    endfunction
    assign rom_spo = rom_f(rom_a);

    dir_lut_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_a     (rom_a),
        .rom_spo   (rom_spo),
        .hold      (hold),
        .idle      (idle)
`ifdef DIR_LUT_ARB_STATS_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] a;
        logic        h;
        logic [3:0]  rdy;
        logic [3:0]  rv;
        logic [4:0]  rd;
        logic        idl;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input logic [3:0] v, input logic [31:0] a, input logic h,
                       input logic [3:0] rdy, input logic [3:0] rv, input logic [4:0] rd, input logic idl);
        tbl.push_back('{v, a, h, rdy, rv, rd, idl});
    endtask

    typedef struct {
        int         t;
        int         id;
        logic [4:0] d;
    } pend_t;
    pend_t pq[$];
    int tnow, ptr_m, mode_m;
    logic [7:0] rom_m;
    logic [4:0] data_m;
    int cnt_m[N];

    task automatic model_reset();
        pq.delete();
        tnow = 0;
        ptr_m = N - 1;
        mode_m = 0;
        rom_m = '0;
        data_m = '0;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
    endtask

    // mode_m: 0 granting, 1 draining, 2 paused; responses are due two edges after their accept
    task automatic model_cycle();
        logic [3:0] er, ev;
        bit empty;
        int g;
        er = '0;
        ev = '0;
        g = -1;
        while (pq.size() > 0 && pq[0].t < tnow) void'(pq.pop_front());
        empty = pq.size() == 0;
        if (pq.size() > 0 && pq[0].t == tnow) begin
            ev = 4'(1 << pq[0].id);
            data_m = pq[0].d;
        end
        if (mode_m == 0 && !hold)
            for (int k = 1; k <= N; k++)
                if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        if (g >= 0) er = 4'(1 << g);
        chk($sformatf("rnd%0d req_ready", tnow), 32'(req_ready), 32'(er));
        chk($sformatf("rnd%0d rsp_valid", tnow), 32'(rsp_valid), 32'(ev));
        chk($sformatf("rnd%0d rsp_data", tnow), 32'(rsp_data), 32'(data_m));
        chk($sformatf("rnd%0d idle", tnow), 32'(idle), 32'(mode_m == 2 || empty));
        chk($sformatf("rnd%0d rom_a", tnow), 32'(rom_a), 32'(rom_m));
        if (g >= 0) begin
            ptr_m = g;
            rom_m = req_addr[g*8 +: 8];
            pq.push_back('{tnow + 2, g, rom_f(rom_m)});
            if (cnt_m[g] < 65535) cnt_m[g]++;
        end
        if (mode_m == 0) mode_m = hold ? 1 : 0;
        else if (mode_m == 1) mode_m = !hold ? 0 : empty ? 2 : 1;
        else mode_m = hold ? 2 : 0;
        tnow++;
    endtask

    initial begin
        row(4'b0001, 32'h00, 0, 4'b0001, 4'b0000, 5'h00, 1);
        row(4'b0001, 32'h80, 0, 4'b0001, 4'b0000, 5'h00, 0);
        row(4'b0000, 32'h00, 0, 4'b0000, 4'b0001, 5'h18, 0);
        row(4'b0000, 32'h00, 0, 4'b0000, 4'b0001, 5'h00, 0);
        row(4'b0000, 32'h00, 0, 4'b0000, 4'b0000, 5'h00, 1);
        row(4'b1000, 32'hFF000000, 0, 4'b1000, 4'b0000, 5'h00, 1);
        row(4'b1111, A, 0, 4'b0001, 4'b0000, 5'h00, 0);
        row(4'b1111, A, 0, 4'b0010, 4'b1000, 5'h07, 0);
        row(4'b1111, A, 0, 4'b0100, 4'b0001, 5'h19, 0);
        row(4'b1111, A, 0, 4'b1000, 4'b0010, 5'h1F, 0);
        row(4'b1111, A, 0, 4'b0001, 4'b0100, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b1000, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0001, 5'h19, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h19, 1);
        row(4'b1000, A, 0, 4'b1000, 4'b0000, 5'h19, 1);
        row(4'b0100, A, 0, 4'b0100, 4'b0000, 5'h19, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b1000, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0100, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h07, 1);
        row(4'b1111, A, 0, 4'b1000, 4'b0000, 5'h07, 1);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b1000, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h07, 1);
        row(4'b0011, A, 0, 4'b0001, 4'b0000, 5'h07, 1);
        row(4'b0011, A, 0, 4'b0010, 4'b0000, 5'h07, 0);
        row(4'b0011, A, 1, 4'b0000, 4'b0001, 5'h19, 0);
        row(4'b0011, A, 1, 4'b0000, 4'b0010, 5'h1F, 0);
        row(4'b0011, A, 1, 4'b0000, 4'b0000, 5'h1F, 1);
        row(4'b0011, A, 1, 4'b0000, 4'b0000, 5'h1F, 1);
        row(4'b0011, A, 0, 4'b0000, 4'b0000, 5'h1F, 1);
        row(4'b0011, A, 0, 4'b0001, 4'b0000, 5'h1F, 1);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h1F, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0001, 5'h19, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h19, 1);
        row(4'b0100, A, 0, 4'b0100, 4'b0000, 5'h19, 1);
        row(4'b0000, A, 1, 4'b0000, 4'b0000, 5'h19, 0);
        row(4'b0001, A, 0, 4'b0000, 4'b0100, 5'h07, 0);
        row(4'b0001, A, 0, 4'b0001, 4'b0000, 5'h07, 1);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h07, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0001, 5'h19, 0);
        row(4'b0000, A, 0, 4'b0000, 4'b0000, 5'h19, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", 32'(rsp_data), 0);
        chk("reset rom_a", 32'(rom_a), 0);
        chk("reset idle", 32'(idle), 1);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[r]) begin
            req_valid = tbl[r].v;
            req_addr = tbl[r].a;
            hold = tbl[r].h;
            #1;
            chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rv));
            chk($sformatf("row%0d rsp_data", r), 32'(rsp_data), 32'(tbl[r].rd));
            chk($sformatf("row%0d idle", r), 32'(idle), 32'(tbl[r].idl));
            @(negedge clk);
        end

        req_valid = '0;
        hold = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom);
            req_addr = $urandom;
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            #1;
            model_cycle();
            @(negedge clk);
        end
`ifdef DIR_LUT_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk($sformatf("grant_cnt%0d", i), 32'(grant_cnt[i*16 +: 16]), 32'(cnt_m[i]));
`endif

        req_valid = '0;
        hold = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr = 32'h55;
        #1;
        chk("rstmid req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("rstmid rom_a accepted", 32'(rom_a), 32'h55);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rstmid rom_a", 32'(rom_a), 0);
        chk("rstmid idle", 32'(idle), 1);
        chk("rstmid rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rstafter%0d rsp_valid", c), 32'(rsp_valid), 0);
            chk($sformatf("rstafter%0d idle", c), 32'(idle), 1);
            chk($sformatf("rstafter%0d rom_a", c), 32'(rom_a), 0);
            @(negedge clk);
        end

`ifdef DIR_LUT_ARB_STATS_EN
        req_valid = 4'b0010;
        req_addr = A;
        repeat (70000) @(negedge clk);
        req_valid = '0;
        #1;
        chk("stats sat cnt1", 32'(grant_cnt[31:16]), 32'hFFFF);
        chk("stats cnt0", 32'(grant_cnt[15:0]), 0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("stats clr cnt1", 32'(grant_cnt[31:16]), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dir_lut_arbiter.md
Name: dir_lut_arbiter

Overview:
- Shares one combinational orientation-bin lookup ROM (8-bit address in, 5-bit bin out) among NUM_REQ keypoint-orientation requesters.
- Uses round-robin arbitration, a 2-stage registered pipeline (address register, then data register), and a hold/drain control for ROM reconfiguration.
- Sits between the gradient-angle units and the direction ROM, ahead of the orientation histogram stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width.
- DATA_W, 5, ROM data (bin index) width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
- rsp_valid  output  NUM_REQ  one-hot response strobe, registered.
- rsp_data  output  DATA_W  bin result for the requester flagged in rsp_valid.
- rom_a  output  ADDR_W  registered address to the external ROM.
- rom_spo  input  DATA_W  ROM data, combinational from rom_a.
- hold  input  1  stop accepting new requests.
- idle  output  1  high when no transaction is in flight.

Behaviour:
- Reset (async, rst=1): rr_ptr=NUM_REQ-1, s1_vld=0, s1_id=0, rom_a=0, rsp_valid=0, rsp_data=0, idle=1, FSM=RUN.
- req_ready:
  - At most one bit is set.
  - It is the first i with req_valid[i]=1, searching from rr_ptr+1 modulo NUM_REQ upward.
  - It is forced all-zero when FSM is not RUN.
- Accept = req_valid[i] & req_ready[i].
  - On accept: rom_a<=req_addr[i], s1_vld<=1, s1_id<=i, rr_ptr<=i.
  - On a cycle with no accept: s1_vld<=0; rom_a and rr_ptr hold.
- Stage 2 registers: rsp_valid<=s1_vld ? onehot(s1_id) : 0, and rsp_data<=rom_spo when s1_vld; otherwise rsp_data holds.
- Latency: response appears 2 cycles after the accept edge. Throughput is 1 per cycle, with no bubbles under continuous requests.
- rsp has no backpressure; consumers must sink rsp_valid every cycle.
- Requesters hold valid and addr stable until accepted; dropping valid before accept is legal, and the request is simply lost.
- Round-robin wrap: after granting NUM_REQ-1, the search starts at 0. A single active requester is granted every cycle.
- FSM states:
  - RUN → DRAIN when hold=1.
  - DRAIN → PAUSED when s1_vld=0 and rsp_valid=0.
  - PAUSED → RUN when hold=0.
  - DRAIN → RUN if hold drops before the pipeline empties.
- hold is sampled combinationally: req_ready is zero in the same cycle hold rises.
- idle = (FSM==PAUSED) | (s1_vld==0 & rsp_valid==0). The ROM may be swapped only while FSM==PAUSED.
- Reset mid-transaction: in-flight results are discarded and no rsp_valid is produced afterward.

Optional Feature:
- Macro: DIR_LUT_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, width NUM_REQ*16: per-requester 16-bit counters, incremented on each accept, saturating at 16'hFFFF.
  - Adds input cnt_clr, a synchronous clear for all counters.
  - Counters reset to 0 on rst.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package dir_lut_pkg holds:
  - DIR_ADDR_W=8 and DIR_DATA_W=5.
  - FSM state encoding: RUN=2'd0, DRAIN=2'd1, PAUSED=2'd2.
  - Function rr_pick(valid, ptr), returning the one-hot grant.
- One natural sub-module: rr_arbiter, combinational one-hot pick plus the rr_ptr register, reused by other shared-ROM controllers.

Test Plan:
- Single requester 0, addr 0x00 then 0x80 on consecutive cycles → rsp_valid=4'b0001 with rsp_data 0x18 then 0x00, each 2 cycles after its accept.
- All 4 requesters valid continuously with addrs 0x10, 0x7F, 0xF0, 0xFF → grants in order 0,1,2,3,0,…; responses 0x19, 0x1F, 0x07, 0x07 with one-hot ids matching; no idle cycles.
- Requester 2 alone after a grant to 3 (wrap) → req_ready=4'b0100 the same cycle; rr_ptr becomes 2.
- hold asserted with 2 in flight → req_ready=0 immediately; rsp_valid pulses twice; idle=1 and FSM=PAUSED on the next cycle; hold released → grants resume the next cycle.
- rst pulsed 1 cycle after an accept → rsp_valid stays 0; rom_a=0; idle=1.
- With DIR_LUT_ARB_STATS_EN: 70000 accepts on requester 1 → grant_cnt[31:16]=16'hFFFF; cnt_clr → 0 the next cycle.
